// File: rtl/acc_requant_drain.sv
// -----------------------------------------------------------------------------
// acc_requant_drain
//
// Drain stage behind one systolic-array column of accumulators. A finished
// vector of R signed accumulators is captured in a single beat. Each lane is
// requantized (arithmetic right shift by Shift, round-half-up, saturate to
// WidthO). The lanes are then streamed out one per handshake, lane 0 first.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   s_valid_i    : accumulator vector valid (column "done" strobe)
//   s_ready_o    : a vector can be captured this cycle
//   s_data_i     : R lanes, lane i at [i*WidthY +: WidthY], signed
//   m_valid_o    : output element valid
//   m_ready_i    : downstream accepts the element
//   m_data_o     : requantized signed element
//   m_last_o     : marks lane R-1, the final element of a vector
//   dbg_state_o  : current FSM state (0 = IDLE, 1 = SEND)
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. A source holds valid and its payload stable
// until that transfer. Ready may depend on valid; valid never depends on ready.
// -----------------------------------------------------------------------------
module acc_requant_drain #(
    parameter int R      = 4,
    parameter int WidthY = 16,
    parameter int WidthO = 8,
    parameter int Shift  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [R*WidthY-1:0]   s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WidthO-1:0]     m_data_o,
    output logic                  m_last_o,
    output logic                  dbg_state_o
);

    localparam int IW = $clog2(R);
    localparam logic [IW-1:0] LastIdx = IW'(R - 1);

    // Rounding bias 2^(Shift-1), or 0 when Shift is 0.
    localparam logic signed [WidthY:0] Rnd  = ((WidthY+1)'(1) << Shift) >>> 1;
    localparam logic signed [WidthY:0] QMax = (WidthY+1)'((1 << (WidthO - 1)) - 1);
    localparam logic signed [WidthY:0] QMin = -QMax - (WidthY+1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [R*WidthY-1:0]   buf_q;
    logic                  capture;
    logic                  at_last;

    assign at_last = (idx_q == LastIdx);

    // The only input-to-output combinational path. A new vector is accepted
    // either from IDLE or in the same cycle the final lane hands off, which
    // gives zero-bubble back-to-back vectors.
    always_comb begin
        s_ready_o = 1'b0;
        if (!rst_i) begin
            s_ready_o = (state_q == IDLE) ||
                        ((state_q == SEND) && at_last && m_ready_i);
        end
    end

    assign capture = s_valid_i && s_ready_o;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (m_ready_i) begin
                    if (at_last) begin
                        idx_d = '0;
                        if (!capture) begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                buf_q <= s_data_i;
            end
        end
    end

    // Requantization of the currently selected lane; depends on registered
    // state only, so the output stays stable under backpressure.
    logic signed [WidthY-1:0] lane;
    logic signed [WidthY:0]   t_sum;
    logic signed [WidthY:0]   q_shr;

    assign lane  = buf_q[idx_q*WidthY +: WidthY];
    assign t_sum = {lane[WidthY-1], lane} + Rnd;
    assign q_shr = t_sum >>> Shift;

    always_comb begin
        m_data_o = q_shr[WidthO-1:0];
        if (q_shr > QMax) begin
            m_data_o = QMax[WidthO-1:0];
        end else if (q_shr < QMin) begin
            m_data_o = QMin[WidthO-1:0];
        end
    end

    assign m_valid_o   = (state_q == SEND);
    assign m_last_o    = (state_q == SEND) && at_last;
    assign dbg_state_o = state_q;

endmodule
